// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory port between the memory stage (master) and the memory (slave)
interface mem_stage_if #(parameter int ADDR_W = 17);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: latches ALU results, runs one load/store on the data-memory port and produces writeback
module mem_stage #(parameter int ADDR_W = 17) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n_stall,
    input  logic             ex_valid,
    input  logic             ex_load,
    input  logic             ex_store,
    input  logic             ex_wen,
    input  logic [5:0]       ex_rd,
    input  logic [31:0]      ex_res,
    input  logic [31:0]      ex_sdata,
    mem_stage_if.master      mem,
    output logic             mem_nstall,
    output logic [31:0]      mem_fwd,
    output logic             wb_we,
    output logic [5:0]       wb_rd,
    output logic [31:0]      wb_data
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0]  state;
    logic        s_valid, s_load, s_store, s_wen;
    logic [5:0]  s_rd;
    logic [31:0] s_res, s_sdata, ldata;
    always_comb begin
        mem_nstall    = (state == IDLE) | (state == DONE);
        mem_fwd       = s_load ? ldata : s_res;
        mem.mem_req   = state == REQ;
        mem.mem_we    = (state == REQ) & s_store;
        mem.mem_addr  = s_res[ADDR_W+1:2];
        mem.mem_wdata = s_sdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_valid <= 1'b0;
            s_load  <= 1'b0;
            s_store <= 1'b0;
            s_wen   <= 1'b0;
            s_rd    <= '0;
            s_res   <= '0;
            s_sdata <= '0;
            ldata   <= '0;
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (n_stall) begin
            state   <= (ex_valid & (ex_load | ex_store)) ? REQ : IDLE;
            s_valid <= ex_valid;
            s_load  <= ex_load;
            s_store <= ex_store;
            s_wen   <= ex_wen;
            s_rd    <= ex_rd;
            s_res   <= ex_res;
            s_sdata <= ex_sdata;
            wb_we   <= s_valid & s_wen & ~s_store & mem_nstall;
            wb_rd   <= s_rd;
            wb_data <= mem_fwd;
        end else begin
            // rvalid outside REQ-with-ready or WAIT is stale and never captured
            case (state)
                REQ: if (mem.mem_ready) begin
                    if (s_store) state <= DONE;
                    else if (mem.mem_rvalid) begin
                        ldata <= mem.mem_rdata;
                        state <= DONE;
                    end else state <= WAIT;
                end
                WAIT: if (mem.mem_rvalid) begin
                    ldata <= mem.mem_rdata;
                    state <= DONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with hand-computed expectations
module tb_mem_stage;
    logic        clk = 1'b0, rst = 1'b1, adv = 1'b1;
    logic        n_stall, ex_valid, ex_load, ex_store, ex_wen;
    logic [5:0]  ex_rd, wb_rd;
    logic [31:0] ex_res, ex_sdata, mem_fwd, wb_data;
    logic        mem_nstall, wb_we;
    int          n_chk = 0, n_fail = 0;

    mem_stage_if #(.ADDR_W(17)) mif();

    mem_stage #(.ADDR_W(17)) dut (
        .clk(clk), .rst(rst), .n_stall(n_stall),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_wen(ex_wen),
        .ex_rd(ex_rd), .ex_res(ex_res), .ex_sdata(ex_sdata),
        .mem(mif.master), .mem_nstall(mem_nstall), .mem_fwd(mem_fwd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    assign n_stall = adv & mem_nstall;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic wen, input logic [5:0] rd,
                         input logic [31:0] res, input logic [31:0] sd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_wen = wen;
        ex_rd = rd; ex_res = res; ex_sdata = sd;
    endtask

    initial begin
        ex_valid = 0; ex_load = 0; ex_store = 0; ex_wen = 0; ex_rd = 0; ex_res = 0; ex_sdata = 0;
        mif.mem_ready = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_req", mif.mem_req, 0);
        chk("rst_nstall", mem_nstall, 1);
        chk("rst_fwd", mem_fwd, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);

        // plain ALU op
        issue(0, 0, 1, 6'd5, 32'h1234, 0);
        tick();
        ex_valid = 0;
        chk("alu_nstall", mem_nstall, 1);
        chk("alu_fwd", mem_fwd, 32'h1234);
        tick();
        chk("alu_wb_we", wb_we, 1);
        chk("alu_wb_rd", wb_rd, 5);
        chk("alu_wb_data", wb_data, 32'h1234);

        // load: ready first REQ cycle, rvalid one cycle later
        issue(1, 0, 1, 6'h21, 32'h10, 0);
        tick();
        ex_valid = 0;
        chk("ld_req", mif.mem_req, 1);
        chk("ld_we", mif.mem_we, 0);
        chk("ld_addr", mif.mem_addr, 4);
        chk("ld_stall1", mem_nstall, 0);
        mif.mem_ready = 1;
        tick();
        mif.mem_ready = 0;
        chk("ld_wait_req", mif.mem_req, 0);
        chk("ld_stall2", mem_nstall, 0);
        mif.mem_rvalid = 1; mif.mem_rdata = 32'hDEADBEEF;
        tick();
        mif.mem_rvalid = 0;
        chk("ld_done", mem_nstall, 1);
        chk("ld_fwd", mem_fwd, 32'hDEADBEEF);
        tick();
        chk("ld_wb_we", wb_we, 1);
        chk("ld_wb_rd", wb_rd, 6'h21);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);

        // store with ready delayed 3 cycles
        issue(0, 1, 1, 6'd3, 32'h20, 32'hA5A5A5A5);
        tick();
        ex_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("st_req", mif.mem_req, 1);
            chk("st_we", mif.mem_we, 1);
            chk("st_addr", mif.mem_addr, 8);
            chk("st_wdata", mif.mem_wdata, 32'hA5A5A5A5);
            chk("st_stall", mem_nstall, 0);
            mif.mem_ready = (i == 3);
            tick();
        end
        mif.mem_ready = 0;
        chk("st_done", mem_nstall, 1);
        chk("st_req_off", mif.mem_req, 0);
        tick();
        chk("st_wb_we", wb_we, 0);

        // load with ready and rvalid together
        issue(1, 0, 1, 6'd7, 32'h40, 0);
        tick();
        ex_valid = 0;
        chk("ld1_stall", mem_nstall, 0);
        mif.mem_ready = 1; mif.mem_rvalid = 1; mif.mem_rdata = 32'hCAFEF00D;
        tick();
        mif.mem_ready = 0; mif.mem_rvalid = 0;
        chk("ld1_done", mem_nstall, 1);
        tick();
        chk("ld1_wb_we", wb_we, 1);
        chk("ld1_wb_rd", wb_rd, 7);
        chk("ld1_wb_data", wb_data, 32'hCAFEF00D);

        // load then add back to back
        issue(1, 0, 1, 6'd8, 32'h80, 0);
        tick();
        issue(0, 0, 1, 6'd9, 32'h5555, 0);
        mif.mem_ready = 1;
        tick();
        mif.mem_ready = 0;
        chk("b2b_hold_addr", mif.mem_addr, 32'h20);
        chk("b2b_stall", mem_nstall, 0);
        mif.mem_rvalid = 1; mif.mem_rdata = 32'h11112222;
        tick();
        mif.mem_rvalid = 0;
        chk("b2b_ld_fwd", mem_fwd, 32'h11112222);
        tick();
        ex_valid = 0;
        chk("b2b_wb1_we", wb_we, 1);
        chk("b2b_wb1_rd", wb_rd, 8);
        chk("b2b_wb1_data", wb_data, 32'h11112222);
        chk("b2b_add_fwd", mem_fwd, 32'h5555);
        tick();
        chk("b2b_wb2_we", wb_we, 1);
        chk("b2b_wb2_rd", wb_rd, 9);
        chk("b2b_wb2_data", wb_data, 32'h5555);

        // reset during WAIT, then a stale rvalid
        issue(1, 0, 1, 6'd10, 32'h100, 0);
        tick();
        ex_valid = 0;
        mif.mem_ready = 1;
        tick();
        mif.mem_ready = 0;
        chk("rw_wait_req", mif.mem_req, 0);
        chk("rw_wait_stall", mem_nstall, 0);
        rst = 1;
        tick();
        rst = 0;
        mif.mem_rvalid = 1; mif.mem_rdata = 32'h00000BAD;
        chk("rw_req", mif.mem_req, 0);
        chk("rw_nstall", mem_nstall, 1);
        chk("rw_wb_we", wb_we, 0);
        tick();
        mif.mem_rvalid = 0;
        chk("rw_fwd", mem_fwd, 0);
        chk("rw_wb_we2", wb_we, 0);
        chk("rw_wb_data", wb_data, 0);

        // address wrap and dropped byte offset
        issue(1, 0, 1, 6'd11, 32'h0008_0007, 0);
        tick();
        ex_valid = 0;
        chk("wrap_addr", mif.mem_addr, 1);
        mif.mem_ready = 1; mif.mem_rvalid = 1; mif.mem_rdata = 32'h0BADF00D;
        tick();
        mif.mem_ready = 0; mif.mem_rvalid = 0;
        tick();
        chk("wrap_wb_data", wb_data, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
